// File: rtl/wb_arbiter_4_sched.sv
// ---------------------------------------------------------------------------------------------
// wb_arbiter_4_sched
//   Pipelined Wishbone arbiter that shares one downstream port between four masters.
//   It manages the whole bus cycle: grant, hold, release and park. Arbitration is either
//   round-robin or fixed priority. When the grant is parked on port 0, an idle port 0 request
//   is forwarded in the same cycle.
//
//   Optional feature (macro WB_ARB_TIMEOUT_EN): a watchdog aborts a cycle that has waited
//   TIMEOUT_CYCLES cycles without ack/err. The owner gets an err, then the port is drained
//   until the owner drops cyc. Without the macro, o_timeout_pulse and o_timeout_master are 0.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wbm_*               master requests, flattened; slot i belongs to requester i
//   o_wbm_*               master responses (dat_r/ack/err/stall), flattened per slot
//   o_wbs_*, i_wbs_*      downstream master port toward the address-decoding mux
//   o_grant               one-hot current owner (parked value when idle)
//   o_timeout_pulse       1-cycle pulse on abort
//   o_timeout_master      id of the most recently aborted master
// ---------------------------------------------------------------------------------------------
module wb_arbiter_4_sched #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned ADDR_WIDTH            = 32,
  parameter int unsigned SELECT_WIDTH          = DATA_WIDTH / 8,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b0,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b1,
  parameter bit          ARB_DEFAULT_TO_PORT_0 = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES        = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  // Master side
  input  logic [4*ADDR_WIDTH-1:0]   i_wbm_adr,
  input  logic [4*DATA_WIDTH-1:0]   i_wbm_dat_w,
  input  logic [4*SELECT_WIDTH-1:0] i_wbm_sel,
  input  logic [3:0]                i_wbm_we,
  input  logic [3:0]                i_wbm_cyc,
  input  logic [3:0]                i_wbm_stb,
  output logic [4*DATA_WIDTH-1:0]   o_wbm_dat_r,
  output logic [3:0]                o_wbm_ack,
  output logic [3:0]                o_wbm_err,
  output logic [3:0]                o_wbm_stall,
  // Slave side
  output logic [ADDR_WIDTH-1:0]     o_wbs_adr,
  output logic [DATA_WIDTH-1:0]     o_wbs_dat_w,
  output logic [SELECT_WIDTH-1:0]   o_wbs_sel,
  output logic                      o_wbs_we,
  output logic                      o_wbs_cyc,
  output logic                      o_wbs_stb,
  input  logic [DATA_WIDTH-1:0]     i_wbs_dat_r,
  input  logic                      i_wbs_ack,
  input  logic                      i_wbs_err,
  input  logic                      i_wbs_stall,
  // Status
  output logic [3:0]                o_grant,
  output logic                      o_timeout_pulse,
  output logic [1:0]                o_timeout_master
);

  // Elaboration-time guard: the abort decision looks at TIMEOUT_CYCLES-2.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_arbiter_4_sched: TIMEOUT_CYCLES must be >= 2");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWNED = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
`endif

  localparam logic [3:0] GRANT_PARK = ARB_DEFAULT_TO_PORT_0 ? 4'b0001 : 4'b0000;

  // State registers
  logic [1:0] r_state;
  logic [3:0] r_grant;
  logic [1:0] r_owner;
  logic [1:0] r_rr_last;

  logic [1:0] w_state_nxt;
  logic [3:0] w_grant_nxt;
  logic [1:0] w_owner_nxt;
  logic [1:0] w_rr_last_nxt;

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [1:0]       r_tmo_master;
  logic [CNT_W-1:0] w_tmo_cnt_nxt;
  logic [1:0]       w_tmo_master_nxt;
`endif

  // -------------------------------------------------------------------------------------------
  // Winner selection among current requesters (req = cyc)
  // -------------------------------------------------------------------------------------------
  logic       w_any_req;
  logic [1:0] w_winner;
  logic [1:0] w_rr_idx;

  always_comb begin
    w_any_req = |i_wbm_cyc;
    w_winner  = 2'd0;
    w_rr_idx  = 2'd0;
    if (ARB_TYPE_ROUND_ROBIN) begin
      // Visit candidates from lowest to highest priority; the last hit wins.
      // k=4 wraps to rr_last itself, which is the lowest-priority slot.
      for (int k = 4; k >= 1; k--) begin
        w_rr_idx = r_rr_last + 2'(k);
        if (i_wbm_cyc[w_rr_idx]) w_winner = w_rr_idx;
      end
    end else if (ARB_LSB_HIGH_PRIORITY) begin
      for (int i = 3; i >= 0; i--) begin
        if (i_wbm_cyc[i]) w_winner = 2'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i_wbm_cyc[i]) w_winner = 2'(i);
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Forwarding path selection
  // -------------------------------------------------------------------------------------------
  logic       w_zero_lat;
  logic       w_fwd;
  logic [1:0] w_fwd_id;

  always_comb begin
    // r_grant[0] is only set in IDLE when the grant is parked on port 0. Port 0 is forwarded
    // immediately only if it is also the arbitration winner this cycle.
    w_zero_lat = (r_state == S_IDLE) && r_grant[0] && w_any_req && (w_winner == 2'd0);
    w_fwd      = (r_state == S_OWNED) || w_zero_lat;
    w_fwd_id   = (r_state == S_IDLE) ? 2'd0 : r_owner;
  end

  // -------------------------------------------------------------------------------------------
  // Datapath muxes
  // -------------------------------------------------------------------------------------------
  always_comb begin
    o_wbs_adr   = i_wbm_adr[int'(w_fwd_id)*ADDR_WIDTH +: ADDR_WIDTH];
    o_wbs_dat_w = i_wbm_dat_w[int'(w_fwd_id)*DATA_WIDTH +: DATA_WIDTH];
    o_wbs_sel   = i_wbm_sel[int'(w_fwd_id)*SELECT_WIDTH +: SELECT_WIDTH];
    o_wbs_we    = i_wbm_we[w_fwd_id];
    // Owner dropping cyc releases the slave in that same cycle.
    o_wbs_cyc   = w_fwd & i_wbm_cyc[w_fwd_id];
    o_wbs_stb   = w_fwd & i_wbm_stb[w_fwd_id];

    o_wbm_dat_r = '0;
    o_wbm_ack   = 4'b0000;
    o_wbm_err   = 4'b0000;
    o_wbm_stall = 4'b1111;
    if (w_fwd) begin
      o_wbm_dat_r[int'(w_fwd_id)*DATA_WIDTH +: DATA_WIDTH] = i_wbs_dat_r;
      // err dominates: a slave asserting both never yields an ack.
      o_wbm_ack[w_fwd_id]   = i_wbs_ack & ~i_wbs_err;
      o_wbm_err[w_fwd_id]   = i_wbs_err;
      o_wbm_stall[w_fwd_id] = i_wbs_stall;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (r_state == S_ABORT) o_wbm_err[r_owner] = 1'b1;
`endif
  end

  // -------------------------------------------------------------------------------------------
  // Bus-cycle lifecycle
  // -------------------------------------------------------------------------------------------
  logic w_owner_cyc;
  assign w_owner_cyc = i_wbm_cyc[r_owner];

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_rr_last_nxt = r_rr_last;
`ifdef WB_ARB_TIMEOUT_EN
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_tmo_master_nxt = r_tmo_master;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_OWNED;
          w_grant_nxt = 4'b0001 << w_winner;
          w_owner_nxt = w_winner;
`ifdef WB_ARB_TIMEOUT_EN
          w_tmo_cnt_nxt = '0;
`endif
        end
      end

      S_OWNED: begin
        if (!w_owner_cyc) begin
          // Requests seen this cycle are arbitrated next cycle from IDLE.
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = GRANT_PARK;
          w_rr_last_nxt = r_owner;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (i_wbs_ack || i_wbs_err) begin
          w_tmo_cnt_nxt = '0;
        end else begin
          if (r_tmo_cnt != CNT_MAX) w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
          // Counter reaches TIMEOUT_CYCLES-1 on this edge: the abort cycle is the
          // TIMEOUT_CYCLES-th cycle of the grant without a response.
          if (r_tmo_cnt == CNT_LAST) begin
            w_state_nxt      = S_ABORT;
            w_tmo_master_nxt = r_owner;
          end
        end
`endif
      end

`ifdef WB_ARB_TIMEOUT_EN
      S_ABORT: begin
        w_state_nxt = S_DRAIN;
      end

      S_DRAIN: begin
        // Slave is already disconnected; late responses are dropped.
        if (!w_owner_cyc) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = GRANT_PARK;
          w_rr_last_nxt = r_owner;
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = GRANT_PARK;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= GRANT_PARK;
      r_owner   <= 2'd0;
      r_rr_last <= 2'd3;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_last_nxt;
    end
  end

  assign o_grant = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt    <= '0;
      r_tmo_master <= 2'd0;
    end else begin
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_tmo_master <= w_tmo_master_nxt;
    end
  end

  assign o_timeout_pulse  = (r_state == S_ABORT);
  assign o_timeout_master = r_tmo_master;
`else
  assign o_timeout_pulse  = 1'b0;
  assign o_timeout_master = 2'b00;
`endif

endmodule
